// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handoff and redirect input.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high; an unaccepted
// imem request may be withdrawn only by a redirect; imem_rsp_valid has no ready and is a one-cycle pulse.
interface instr_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned INSTR_LEN  = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_rsp_valid;
    logic [INSTR_LEN-1:0]  imem_rsp_data;
    logic [INSTR_LEN-1:0]  instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, instr, instr_pc, instr_valid,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr, instr_pc, instr_valid,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: owns the PC, issues one imem read at a time and hands each
// returned word with its PC to decode; redirects override the sequential +4 step.
module instr_fetch #(
    parameter int unsigned           ADDR_WIDTH = 64,
    parameter int unsigned           INSTR_LEN  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus,
    output logic [1:0]    o_state,
    output logic          o_drop_flag
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  r_drop;
    logic                  w_drop_nxt;
    logic [INSTR_LEN-1:0]  r_instr;
    logic [INSTR_LEN-1:0]  w_instr_nxt;
    logic [ADDR_WIDTH-1:0] r_instr_pc;
    logic [ADDR_WIDTH-1:0] w_instr_pc_nxt;
    logic [ADDR_WIDTH-1:0] w_target;
    logic [ADDR_WIDTH-1:0] w_pc_seq;

    assign w_target = bus.redirect_pc & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
    assign w_pc_seq = r_pc + ADDR_WIDTH'(4);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_drop_nxt     = r_drop;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                if (bus.redirect_valid) begin
                    w_pc_nxt = w_target;
                end
            end
            S_FETCH: begin
                if (bus.redirect_valid) begin
                    w_pc_nxt = w_target;
                end
                // A redirect racing an accepted request marks that request's response as stale.
                if (bus.imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                    w_drop_nxt  = bus.redirect_valid;
                end
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    w_drop_nxt = 1'b0;
                    if (bus.redirect_valid) begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = S_FETCH;
                    end else if (r_drop) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_instr_nxt    = bus.imem_rsp_data;
                        w_instr_pc_nxt = r_pc;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    w_pc_nxt   = w_target;
                    w_drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                // Redirect wins over +4 even when decode takes the held word this cycle.
                if (bus.redirect_valid) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_FETCH;
                end else if (bus.instr_ready) begin
                    w_pc_nxt    = w_pc_seq;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
        end
    end

    assign bus.imem_req_valid = (r_state == S_FETCH);
    assign bus.imem_addr      = r_pc;
    assign bus.instr_valid    = (r_state == S_HOLD);
    assign bus.instr          = r_instr;
    assign bus.instr_pc       = r_instr_pc;
    assign o_state            = r_state;
    assign o_drop_flag        = r_drop;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then randomized traffic, checked against a
// transaction-level model of the expected fetch/delivery PC stream.
module tb_instr_fetch;
    localparam int unsigned   AW       = 64;
    localparam int unsigned   IL       = 32;
    localparam logic [AW-1:0] RESET_PC = '0;
    localparam logic [AW-1:0] WRAP_PC  = 64'hFFFF_FFFF_FFFF_FFFC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    logic       dbg_drop;
    logic [1:0] w_dbg_state;
    logic       w_dbg_drop;

    instr_fetch_if #(.ADDR_WIDTH(AW), .INSTR_LEN(IL)) m_if ();
    instr_fetch_if #(.ADDR_WIDTH(AW), .INSTR_LEN(IL)) w_if ();

    instr_fetch #(.ADDR_WIDTH(AW), .INSTR_LEN(IL), .RESET_PC(RESET_PC)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(m_if), .o_state(dbg_state), .o_drop_flag(dbg_drop)
    );
    instr_fetch #(.ADDR_WIDTH(AW), .INSTR_LEN(IL), .RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(w_if), .o_state(w_dbg_state), .o_drop_flag(w_dbg_drop)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass = 0;
    int            n_delivered = 0;
    logic [AW-1:0] exp_pc = RESET_PC;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    int            lat_cnt = 0;
    int            fixed_lat = 0;
    logic          rand_lat = 1'b0;
    int            rdy_mode = 0;
    logic          last_dec_fire = 1'b0;

    function automatic logic [IL-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 64'd0) return 32'h8B02_0020;
        if (a == 64'd4) return 32'hCB03_0041;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_5A13;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: drive memory, score handshakes against the model, advance to the next negedge.
    task automatic tick();
        logic rsp_now;
        logic req_fire;
        logic dec_fire;
        logic w_next;
        rsp_now = pend && (lat_cnt == 0);
        m_if.imem_rsp_valid = rsp_now;
        m_if.imem_rsp_data  = rsp_now ? mem_word(pend_addr) : IL'($urandom);
        m_if.imem_req_ready = !pend && ((rdy_mode == 0) || ((rdy_mode == 1) && ($urandom_range(0, 2) != 0)));
        req_fire = m_if.imem_req_valid && m_if.imem_req_ready;
        dec_fire = m_if.instr_valid && m_if.instr_ready;
        if (rst_n) begin
            last_dec_fire = dec_fire;
            if (req_fire) chk("req_addr", m_if.imem_addr, exp_pc);
            if (dec_fire) begin
                chk("dec_pc", m_if.instr_pc, exp_pc);
                chk("dec_data", 64'(m_if.instr), 64'(mem_word(exp_pc)));
                n_delivered++;
            end
            if (m_if.redirect_valid) exp_pc = m_if.redirect_pc & ~64'd3;
            else if (dec_fire) exp_pc = exp_pc + 64'd4;
        end else begin
            last_dec_fire = 1'b0;
            exp_pc = RESET_PC;
        end
        if (rsp_now) pend = 1'b0;
        else if (pend) lat_cnt--;
        if (req_fire) begin
            pend      = 1'b1;
            pend_addr = m_if.imem_addr;
            lat_cnt   = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        end
        w_next = rst_n && w_if.imem_req_valid;
        @(posedge clk);
        @(negedge clk);
        m_if.redirect_valid = 1'b0;
        w_if.imem_rsp_valid = w_next;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!m_if.imem_req_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_req", m_if.imem_req_valid, 1'b1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!m_if.instr_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_valid", m_if.instr_valid, 1'b1);
    endtask

    task automatic redirect(input logic [AW-1:0] target);
        m_if.redirect_valid = 1'b1;
        m_if.redirect_pc    = target;
    endtask

    initial begin
        logic          hold_chk;
        logic [IL-1:0] held_instr;
        logic [AW-1:0] held_pc;
        rst_n = 1'b0;
        m_if.imem_req_ready = 1'b1;
        m_if.imem_rsp_valid = 1'b0;
        m_if.imem_rsp_data  = '0;
        m_if.instr_ready    = 1'b1;
        m_if.redirect_valid = 1'b0;
        m_if.redirect_pc    = '0;
        w_if.imem_req_ready = 1'b1;
        w_if.imem_rsp_valid = 1'b0;
        w_if.imem_rsp_data  = 32'h0000_0013;
        w_if.instr_ready    = 1'b1;
        w_if.redirect_valid = 1'b0;
        w_if.redirect_pc    = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_req_valid", m_if.imem_req_valid, 0);
        chk("rst_instr_valid", m_if.instr_valid, 0);
        chk("rst_instr", 64'(m_if.instr), 0);
        chk("rst_instr_pc", m_if.instr_pc, 0);
        chk("rst_addr", m_if.imem_addr, RESET_PC);
        chk("rst_state", dbg_state, 0);
        chk("rst_drop", dbg_drop, 0);
        chk("wrap_rst_addr", w_if.imem_addr, WRAP_PC);
        chk("wrap_rst_state", w_dbg_state, 0);

        // Zero-wait memory, first two instructions
        rst_n = 1'b1;
        tick();
        chk("first_req_valid", m_if.imem_req_valid, 1);
        chk("first_addr", m_if.imem_addr, 0);
        chk("c1_instr_valid", m_if.instr_valid, 0);
        chk("wrap_first_addr", w_if.imem_addr, WRAP_PC);
        tick();
        chk("c2_instr_valid", m_if.instr_valid, 0);
        tick();
        chk("c3_instr_valid", m_if.instr_valid, 1);
        chk("c3_instr", 64'(m_if.instr), 64'h8B02_0020);
        chk("c3_instr_pc", m_if.instr_pc, 0);
        tick();
        chk("seq_req_valid", m_if.imem_req_valid, 1);
        chk("seq_addr", m_if.imem_addr, 4);
        chk("wrap_seq_addr", w_if.imem_addr, 0);
        chk("wrap_seq_req", w_if.imem_req_valid, 1);
        chk("wrap_drop", w_dbg_drop, 0);
        tick();
        tick();
        chk("second_valid", m_if.instr_valid, 1);
        chk("second_pc", m_if.instr_pc, 4);
        chk("second_instr", 64'(m_if.instr), 64'hCB03_0041);

        // Decode backpressure
        m_if.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", m_if.instr_valid, 1);
            chk("bp_instr", 64'(m_if.instr), 64'hCB03_0041);
            chk("bp_pc", m_if.instr_pc, 4);
            chk("bp_req_valid", m_if.imem_req_valid, 0);
        end
        m_if.instr_ready = 1'b1;
        tick();
        chk("bp_next_req", m_if.imem_req_valid, 1);
        chk("bp_next_addr", m_if.imem_addr, 8);

        // Memory backpressure at 0x10
        tick();
        wait_req(20);
        tick();
        wait_req(20);
        chk("mbp_start_addr", m_if.imem_addr, 64'h10);
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mbp_req_valid", m_if.imem_req_valid, 1);
            chk("mbp_addr", m_if.imem_addr, 64'h10);
            chk("mbp_instr_valid", m_if.instr_valid, 0);
        end
        rdy_mode = 0;
        tick();
        chk("mbp_wait_valid", m_if.instr_valid, 0);
        tick();
        chk("mbp_rsp_valid", m_if.instr_valid, 1);
        chk("mbp_rsp_pc", m_if.instr_pc, 64'h10);

        // Redirect while waiting, stale response must vanish
        tick();
        fixed_lat = 2;
        tick();
        redirect(64'h1000);
        tick();
        chk("rw_drop_set", dbg_drop, 1);
        chk("rw_valid_a", m_if.instr_valid, 0);
        tick();
        chk("rw_valid_b", m_if.instr_valid, 0);
        tick();
        chk("rw_valid_c", m_if.instr_valid, 0);
        chk("rw_req_valid", m_if.imem_req_valid, 1);
        chk("rw_addr", m_if.imem_addr, 64'h1000);
        fixed_lat = 1;
        tick();
        redirect(64'h1002);
        tick();
        tick();
        chk("rw_mis_valid", m_if.instr_valid, 0);
        chk("rw_mis_req", m_if.imem_req_valid, 1);
        chk("rw_mis_addr", m_if.imem_addr, 64'h1000);
        fixed_lat = 0;

        // Redirect in HOLD, with and without a decode handshake
        wait_valid(20);
        redirect(64'h200);
        tick();
        chk("rh_handshake", last_dec_fire, 1);
        chk("rh_valid_drop", m_if.instr_valid, 0);
        chk("rh_addr", m_if.imem_addr, 64'h200);
        wait_valid(20);
        m_if.instr_ready = 1'b0;
        redirect(64'h300);
        tick();
        chk("rh_nohs", last_dec_fire, 0);
        chk("rh_nohs_valid", m_if.instr_valid, 0);
        chk("rh_nohs_addr", m_if.imem_addr, 64'h300);
        m_if.instr_ready = 1'b1;

        // PC wraps past the top of the address space
        redirect(64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        wait_valid(20);
        chk("wrap_top_pc", m_if.instr_pc, WRAP_PC);
        tick();
        chk("wrap_next_addr", m_if.imem_addr, 0);

        // Reset mid-WAIT, late response after release is ignored
        wait_req(20);
        fixed_lat = 1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        fixed_lat = 0;
        tick();
        chk("rr_valid", m_if.instr_valid, 0);
        chk("rr_req_valid", m_if.imem_req_valid, 1);
        chk("rr_addr", m_if.imem_addr, RESET_PC);
        tick();
        tick();
        chk("rr_instr_valid", m_if.instr_valid, 1);
        chk("rr_instr_pc", m_if.instr_pc, RESET_PC);
        chk("rr_instr", 64'(m_if.instr), 64'h8B02_0020);

        // Randomized traffic
        rdy_mode = 1;
        rand_lat = 1'b1;
        n_delivered = 0;
        for (int i = 0; i < 800; i++) begin
            m_if.instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0: redirect(64'($urandom_range(0, 16'hFFFF)));
                    1: redirect(64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)));
                    default: redirect({$urandom, $urandom});
                endcase
            end
            rst_n = ($urandom_range(0, 199) != 0);
            hold_chk   = rst_n && m_if.instr_valid && !m_if.instr_ready && !m_if.redirect_valid;
            held_instr = m_if.instr;
            held_pc    = m_if.instr_pc;
            tick();
            if (hold_chk) begin
                chk("rnd_hold_valid", m_if.instr_valid, 1);
                chk("rnd_hold_instr", 64'(m_if.instr), 64'(held_instr));
                chk("rnd_hold_pc", m_if.instr_pc, held_pc);
            end
        end
        rst_n = 1'b1;
        chk("rnd_progress", 64'(n_delivered > 30), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
